// File: rtl/vga_pattern_gen_if.sv
// vga_pattern_gen_if: timing inputs from hvsync plus the VGA pin/status outputs
// of the pattern generator. Clock and reset stay outside the bundle.
interface vga_pattern_gen_if;
    logic       hsync_in;
    logic       vsync_in;
    logic       display_on;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       mode_next;
    logic       VGA_HS;
    logic       VGA_VS;
    logic [3:0] VGA_R;
    logic [3:0] VGA_G;
    logic [3:0] VGA_B;
    logic [1:0] mode;
    logic [7:0] frame_cnt;

    // Timing source / observer side
    modport master (
        output hsync_in, vsync_in, display_on, hpos, vpos, mode_next,
        input  VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B, mode, frame_cnt
    );

    // Pattern generator side
    modport slave (
        input  hsync_in, vsync_in, display_on, hpos, vpos, mode_next,
        output VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B, mode, frame_cnt
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: two-stage colour pipeline behind hvsync. Stage 1 registers
// the timing inputs and the colour-bar index, stage 2 selects the colour for the
// current mode. Syncs travel alongside so they stay aligned with RGB.
// Optional macro VGA_PAT_BORDER_EN: white 1-pixel border around the active area.
module vga_pattern_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter bit          VS_POL    = 1'b0,
    parameter bit          HS_POL    = 1'b0,
    parameter int unsigned CHK_SHIFT = 5
) (
    input  logic             clk,
    input  logic             reset,
    vga_pattern_gen_if.slave bus
);
    localparam logic [9:0] BAR_LAST = 10'(H_ACTIVE / 8 - 1);

    typedef enum logic [1:0] {
        ModeBars,
        ModeChecker,
        ModeGradient,
        ModeSolid
    } mode_e;

    logic [9:0]  pix_cnt_q, pix_cnt_d, pix_cur;
    logic [2:0]  bar_cnt_q, bar_cnt_d, bar_cur;
    logic        vs_act, vs_act_q, frame_start;
    logic        pending_q, pending_d;
    mode_e       mode_q, mode_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        de_q, hs_q, vs_q;
    logic [9:0]  h_q, v_q;
    logic [2:0]  bar_q;
    logic [11:0] rgb_d, rgb_q;
    logic        hs_out_q, vs_out_q;

    // Bar tracking: both counters restart on hpos==0, bar index saturates at 7
    always_comb begin
        bar_cur   = (bus.hpos == 10'd0) ? 3'd0 : bar_cnt_q;
        pix_cur   = (bus.hpos == 10'd0) ? 10'd0 : pix_cnt_q;
        pix_cnt_d = pix_cur + 10'd1;
        bar_cnt_d = bar_cur;
        if (pix_cur == BAR_LAST) begin
            pix_cnt_d = 10'd0;
            bar_cnt_d = (bar_cur == 3'd7) ? 3'd7 : bar_cur + 3'd1;
        end
    end

    // Bar counter state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_cnt_q <= '0;
            bar_cnt_q <= '0;
        end else begin
            pix_cnt_q <= pix_cnt_d;
            bar_cnt_q <= bar_cnt_d;
        end
    end

    // Frame start detection and mode/frame counter next state
    always_comb begin
        vs_act      = (bus.vsync_in == VS_POL);
        frame_start = vs_act & ~vs_act_q;
        pending_d   = pending_q;
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        if (frame_start) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (pending_q || bus.mode_next) begin
                mode_d    = mode_e'(mode_q + 2'd1);
                pending_d = 1'b0;
            end
        end else if (bus.mode_next) begin
            // Any number of requests in one frame collapse into this one flag
            pending_d = 1'b1;
        end
    end

    // Mode and frame counter state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs_act_q    <= 1'b0;
            pending_q   <= 1'b0;
            mode_q      <= ModeBars;
            frame_cnt_q <= '0;
        end else begin
            vs_act_q    <= vs_act;
            pending_q   <= pending_d;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Stage 1: capture timing inputs and the bar index of this pixel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            de_q  <= 1'b0;
            h_q   <= '0;
            v_q   <= '0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            bar_q <= '0;
        end else begin
            de_q  <= bus.display_on;
            h_q   <= bus.hpos;
            v_q   <= bus.vpos;
            hs_q  <= bus.hsync_in;
            vs_q  <= bus.vsync_in;
            bar_q <= bar_cur;
        end
    end

    // Stage 2 colour select; mode and frame count are the live values
    always_comb begin
        rgb_d = '0;
        unique case (mode_q)
            ModeBars:     rgb_d = {{4{~bar_q[1]}}, {4{~bar_q[2]}}, {4{~bar_q[0]}}};
            ModeChecker:  rgb_d = {12{h_q[CHK_SHIFT] ^ v_q[CHK_SHIFT]}};
            ModeGradient: rgb_d = {h_q[9:6], v_q[9:6], frame_cnt_q[3:0]};
            ModeSolid:    rgb_d = {{4{frame_cnt_q[7]}}, {4{frame_cnt_q[6]}},
                                   {4{frame_cnt_q[5]}}};
        endcase
`ifdef VGA_PAT_BORDER_EN
        if (h_q == 10'd0 || h_q == 10'(H_ACTIVE - 1) ||
            v_q == 10'd0 || v_q == 10'(V_ACTIVE - 1)) begin
            rgb_d = '1;
        end
`endif
        if (!de_q) begin
            rgb_d = '0;
        end
    end

    // Stage 2 output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_q    <= '0;
            hs_out_q <= ~HS_POL;
            vs_out_q <= ~VS_POL;
        end else begin
            rgb_q    <= rgb_d;
            hs_out_q <= hs_q;
            vs_out_q <= vs_q;
        end
    end

    assign bus.VGA_R     = rgb_q[11:8];
    assign bus.VGA_G     = rgb_q[7:4];
    assign bus.VGA_B     = rgb_q[3:0];
    assign bus.VGA_HS    = hs_out_q;
    assign bus.VGA_VS    = vs_out_q;
    assign bus.mode      = mode_q;
    assign bus.frame_cnt = frame_cnt_q;

    // Not every position bit feeds the colour mux in every build
    logic unused_pos;
`ifdef VGA_PAT_BORDER_EN
    assign unused_pos = ^{h_q, v_q};
`else
    assign unused_pos = ^{h_q, v_q, 10'(V_ACTIVE)};
`endif
endmodule
